// File: rtl/mul_share_ctrl.sv
// Two-requester front end for one shared combinational 32x32 multiplier.
// Round-robin grant into S1 (drives the multiplier), result slice captured in S2.
module mul_share_ctrl #(
   parameter int ID_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [1:0]      req0_op_i,
   input  logic [31:0]     req0_x_i,
   input  logic [31:0]     req0_y_i,
   input  logic [ID_W-1:0] req0_id_i,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [1:0]      req1_op_i,
   input  logic [31:0]     req1_x_i,
   input  logic [31:0]     req1_y_i,
   input  logic [ID_W-1:0] req1_id_i,
   output logic            resp0_valid_o,
   input  logic            resp0_ready_i,
   output logic [31:0]     resp0_data_o,
   output logic [ID_W-1:0] resp0_id_o,
   output logic            resp1_valid_o,
   input  logic            resp1_ready_i,
   output logic [31:0]     resp1_data_o,
   output logic [ID_W-1:0] resp1_id_o,
   input  logic [1:0]      flush_i,
   output logic            mul_signed_o,
   output logic [31:0]     mul_x_o,
   output logic [31:0]     mul_y_o,
   input  logic [63:0]     mul_res_i
);

   logic            r_s1_valid;
   logic            r_s1_owner;
   logic [1:0]      r_s1_op;
   logic            r_s1_signed;
   logic [ID_W-1:0] r_s1_id;
   logic [31:0]     r_s1_x;
   logic [31:0]     r_s1_y;
   logic            r_s2_valid;
   logic            r_s2_owner;
   logic [31:0]     r_s2_data;
   logic [ID_W-1:0] r_s2_id;
   logic            r_rr;

   logic            w_s1_flush;
   logic            w_s2_flush;
   logic            w_s2_fire;
   logic            w_s2_free;
   logic            w_s1_adv;
   logic            w_can_accept;
   logic            w_v0;
   logic            w_v1;
   logic            w_grant;
   logic            w_acc0;
   logic            w_acc1;
   logic            w_s1_hi;
   logic [31:0]     w_res_slice;

   assign w_s1_flush = flush_i[r_s1_owner];
   assign w_s2_flush = flush_i[r_s2_owner];

   // Flushed owner never sees its result; the slot simply frees up.
   assign resp0_valid_o = r_s2_valid && !r_s2_owner && !flush_i[0];
   assign resp1_valid_o = r_s2_valid &&  r_s2_owner && !flush_i[1];
   assign resp0_data_o  = r_s2_data;
   assign resp1_data_o  = r_s2_data;
   assign resp0_id_o    = r_s2_id;
   assign resp1_id_o    = r_s2_id;

   assign w_s2_fire    = r_s2_owner ? (resp1_valid_o && resp1_ready_i)
                                    : (resp0_valid_o && resp0_ready_i);
   assign w_s2_free    = !r_s2_valid || w_s2_fire || w_s2_flush;
   assign w_s1_adv     = r_s1_valid && !w_s1_flush && w_s2_free;
   assign w_can_accept = !r_s1_valid || w_s1_adv || w_s1_flush;

   assign w_v0    = req0_valid_i && !flush_i[0];
   assign w_v1    = req1_valid_i && !flush_i[1];
   assign w_grant = (w_v0 && w_v1) ? r_rr : w_v1;

   assign req0_ready_o = w_can_accept && !w_grant && !flush_i[0];
   assign req1_ready_o = w_can_accept &&  w_grant && !flush_i[1];
   assign w_acc0       = req0_valid_i && req0_ready_o;
   assign w_acc1       = req1_valid_i && req1_ready_o;

   assign mul_signed_o = r_s1_signed;
   assign mul_x_o      = r_s1_x;
   assign mul_y_o      = r_s1_y;

   // MULH and MULHU return the upper half; MUL and the reserved code the lower.
   assign w_s1_hi     = (r_s1_op == 2'b01) || (r_s1_op == 2'b10);
   assign w_res_slice = w_s1_hi ? mul_res_i[63:32] : mul_res_i[31:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_owner  <= 1'b0;
         r_s1_op     <= 2'b00;
         r_s1_signed <= 1'b0;
         r_s1_id     <= '0;
         r_s1_x      <= 32'd0;
         r_s1_y      <= 32'd0;
         r_s2_valid  <= 1'b0;
         r_s2_owner  <= 1'b0;
         r_s2_data   <= 32'd0;
         r_s2_id     <= '0;
         r_rr        <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_owner <= r_s1_owner;
            r_s2_data  <= w_res_slice;
            r_s2_id    <= r_s1_id;
         end else if (w_s2_free) begin
            r_s2_valid <= 1'b0;
         end

         if (w_acc0 || w_acc1) begin
            r_s1_valid  <= 1'b1;
            r_s1_owner  <= w_acc1;
            r_s1_op     <= w_acc1 ? req1_op_i : req0_op_i;
            r_s1_signed <= (w_acc1 ? req1_op_i : req0_op_i) != 2'b10;
            r_s1_id     <= w_acc1 ? req1_id_i : req0_id_i;
            r_s1_x      <= w_acc1 ? req1_x_i : req0_x_i;
            r_s1_y      <= w_acc1 ? req1_y_i : req0_y_i;
         end else if (w_s1_adv || w_s1_flush) begin
            r_s1_valid <= 1'b0;
         end

         if (w_acc0) begin
            r_rr <= 1'b1;
         end else if (w_acc1) begin
            r_rr <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Arbitrates one shared 32x32 combinational Booth/Wallace multiplier between two requesters, e.g. two execute pipes.
- Requesters send MUL/MULH/MULHU operations with valid/ready.
- Round-robin arbitration; operands are registered into S1, which drives the multiplier.
- The result slice is registered into S2 and returned to the owning requester with its ID.
- Supports backpressure and per-requester flush.

Parameters:
- ID_W, 4, width of the transaction tag carried from request to response.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- reqN_valid_i  in  1  request valid, N=0,1.
- reqN_ready_o  out  1  request accepted this cycle when valid&ready.
- reqN_op_i  in  2  00 MUL, 01 MULH, 10 MULHU, 11 reserved (treated as MUL).
- reqN_x_i  in  32  multiplicand.
- reqN_y_i  in  32  multiplier.
- reqN_id_i  in  ID_W  tag.
- respN_valid_o  out  1  result valid for requester N.
- respN_ready_i  in  1  requester N consumes the result.
- respN_data_o  out  32  result.
- respN_id_o  out  ID_W  tag of the result.
- flush_i  in  2  bit N kills all of requester N's in-flight work.
- mul_signed_o  out  1  to multiplier.
- mul_x_o  out  32  to multiplier.
- mul_y_o  out  32  to multiplier.
- mul_res_i  in  64  from multiplier, combinational and valid in the same cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - S1/S2 valid cleared, S1 operands zeroed.
  - rr pointer cleared, so req0 has priority.
  - respN_valid_o=0; mul_x_o/mul_y_o/mul_signed_o = 0.
  - Reset mid-operation drops all in-flight work with no response.
- Pipeline:
  - S1 holds {valid, owner, op, id, x, y} and drives mul_* directly from its registers.
  - mul_signed_o = (op==01) || (op==00) || (op==11). MULHU is the only unsigned op.
  - S2 holds {valid, owner, data, id}.
  - data = mul_res_i[31:0] for MUL/reserved, mul_res_i[63:32] for MULH/MULHU.
- Latency: a request accepted at edge t produces respN_valid_o=1 in the cycle after edge t+1, i.e. 2 cycles, when there are no stalls.
- S2 free (s2_free) = !S2.valid || (resp_valid & resp_ready of the owner) || flush_i[owner].
- S1 advance = S1.valid && !flush_i[S1.owner] && s2_free.
- can_accept = !S1.valid || s1_advance || flush_i[S1.owner].
- Arbitration:
  - If both requesters are valid and unflushed, grant the requester at the rr pointer.
  - Otherwise grant whichever is valid.
  - reqN_ready_o = can_accept && grant==N && !flush_i[N]. This is a combinational valid->ready path.
  - Only one accept per cycle.
  - After an accept from N, rr points to 1-N. The pointer does not change without an accept.
- Response:
  - respN_valid_o = S2.valid && S2.owner==N.
  - The other response port is held at valid 0.
  - data and id remain stable while valid && !ready.
- Ordering: responses leave in acceptance order; at most 2 transactions are in flight.
- Flush:
  - flush_i[N] clears S1 and/or S2 entries owned by N at the next edge.
  - It forces reqN_ready_o=0 that cycle and suppresses respN_valid_o.
  - The other requester's work is unaffected and may move into the freed stage the same cycle.
  - Simultaneous flush of both bits empties the pipe.
- Backpressure from S2 stalls S1, which drops can_accept. There are no bubbles beyond the stall.

Test Plan:
- Single MUL: req0 op=00 x=3 y=5 id=2 → resp0_valid 2 cycles later, data=0x0000000F, id=2; resp1_valid stays 0.
- High ops: req1 x=0xFFFFFFFF y=2. MULH → data 0xFFFFFFFF; MULHU → 0x00000001. MUL on the same operands → 0xFFFFFFFE.
- Arbitration:
  - Both valid continuously from reset with resp ready=1 → grants alternate 0,1,0,1.
  - Responses arrive in the same order with the correct ids.
  - Throughput is 1 per cycle.
- Backpressure: resp0_ready=0 for 3 cycles while S1 holds a req1 operation → resp0 data/id stable, both req readies 0. Releasing ready → the req1 result follows the next cycle.
- Flush: req0 in S2, req1 in S1, flush_i=01 → resp0 never valid; req1's result appears the next cycle. Pulse req0 again → accepted normally.
- Reset mid-op: assert rst with both stages full → all resp valids 0 the next cycle and no stale response after deassert. The first accept after reset goes to req0 when both requesters are valid.
